mem_access_unit: RTL and testbench

MEM-stage load/store unit of the 32-bit MIPS pipeline, placed directly upstream of `DataMemory`. It accepts one byte, halfword or word request from the pipeline and drives `DataMemory`'s word-wide `Address`/`r_wbar`/`WriteData`/`ReadData` port. Sub-word stores are performed as read-modify-write sequences, and sub-word loads are returned sign- or zero-extended. A valid/ready handshake on both sides lets the pipeline stall while an access is in progress.

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of DataMemory: byte/half/word accesses, with read-modify-write for sub-word stores.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return resp_err instead of being force-aligned.
module mem_access_unit #(
    parameter int MEM_WORD_ADDR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_r_wbar,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem_addr_q;
    logic        mem_r_wbar_q;
    logic [31:0] mem_wdata_q;

    logic        is_half_s;
    logic        is_word_s;
    logic        trap_s;
    logic [31:0] addr_al_s;
    logic [31:0] mem_addr_s;

    // Replace the addressed lane(s) of a memory word with right-justified store data.
    function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (off)
                    2'b00:   r[7:0]   = data[7:0];
                    2'b01:   r[15:8]  = data[7:0];
                    2'b10:   r[23:16] = data[7:0];
                    default: r[31:24] = data[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[31:16] = data[15:0];
                else        r[15:0]  = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

    // Select the addressed lane of a memory word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Decode size, alignment and the outgoing memory address of the incoming request.
    always_comb begin
        is_half_s = (req_size == 2'b01);
        is_word_s = req_size[1];
        if (is_word_s) begin
            addr_al_s = {req_addr[31:2], 2'b00};
        end else if (is_half_s) begin
            addr_al_s = {req_addr[31:1], 1'b0};
        end else begin
            addr_al_s = req_addr;
        end
        if (MEM_WORD_ADDR != 0) begin
            mem_addr_s = {2'b00, addr_al_s[31:2]};
        end else begin
            mem_addr_s = {addr_al_s[31:2], 2'b00};
        end
`ifdef LSU_MISALIGN_TRAP_EN
        trap_s = (is_half_s && req_addr[0]) || (is_word_s && (req_addr[1:0] != 2'b00));
`else
        trap_s = 1'b0;
`endif
    end

    // Access sequencer: IDLE -> [READ] -> [WRITE] -> RESP, or IDLE -> ERR; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_r_wbar_q <= 1'b1;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        size_q      <= is_word_s ? 2'b10 : req_size;
                        uns_q       <= req_unsigned;
                        off_q       <= addr_al_s[1:0];
                        wdata_q     <= req_wdata;
                        mem_addr_q  <= mem_addr_s;
                        req_ready_q <= 1'b0;
                        if (trap_s) begin
                            state_q      <= ST_ERR;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else if (req_we && is_word_s) begin
                            state_q      <= ST_WRITE;
                            mem_r_wbar_q <= 1'b0;
                            mem_wdata_q  <= req_wdata;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        state_q      <= ST_WRITE;
                        mem_r_wbar_q <= 1'b0;
                        mem_wdata_q  <= merge_word(mem_rdata, wdata_q, off_q, size_q);
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_extend(mem_rdata, off_q, size_q, uns_q);
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_RESP;
                    mem_r_wbar_q <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'h0000_0000;
                end
                ST_RESP, ST_ERR: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_r_wbar_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_r_wbar = mem_r_wbar_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word-indexed DataMemory model (default MEM_WORD_ADDR=1).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_r_wbar;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_r_wbar(mem_r_wbar), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // DataMemory model: combinational read, write on the rising edge while r_wbar is low.
    assign mem_rdata = dmem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (pre_we) dmem[pre_idx] <= pre_data;
        else if (!mem_r_wbar) dmem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pre_idx = idx; pre_data = data; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req_ready"},  {31'b0, req_ready},  32'd1);
        check({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, ".resp_rdata"}, resp_rdata,          32'h0);
        check({tag, ".resp_err"},   {31'b0, resp_err},   32'd0);
        check({tag, ".mem_addr"},   mem_addr,            32'h0);
        check({tag, ".mem_r_wbar"}, {31'b0, mem_r_wbar}, 32'd1);
        check({tag, ".mem_wdata"},  mem_wdata,           32'h0);
    endtask

    // Issue one request and wait (bounded) for resp_valid; lat counts edges from accept to visible response.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int wr_cnt, output logic [31:0] wseen);
        check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1; wr_cnt = 0; wseen = 32'h0;
        while (!resp_valid && lat < 10) begin
            if (!mem_r_wbar) begin
                wr_cnt++;
                wseen = mem_wdata;
            end
            tick();
            lat++;
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_wr, input logic [31:0] exp_wdata);
        int lat, wr_cnt;
        logic [31:0] wseen;
        run_req(tag, we, size, uns, addr, wdata, lat, wr_cnt, wseen);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
        check({tag, ".writes"}, wr_cnt, exp_wr);
        if (exp_wr != 0) check({tag, ".wdata"}, wseen, exp_wdata);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, ".done_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, ".done_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int lat, wr_cnt;
        logic [31:0] wseen;
        logic [31:0] held;

        reset = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b0;
        preload(6'd17, 32'h71FD_6806);
        preload(6'd13, 32'h0000_0000);

        txn("lb_45",  1'b0, 2'b00, 1'b0, 32'h45, 32'h0, 2, 32'h0000_0068, 1'b0, 0, 32'h0);
        txn("lb_46",  1'b0, 2'b00, 1'b0, 32'h46, 32'h0, 2, 32'hFFFF_FFFD, 1'b0, 0, 32'h0);
        txn("lbu_46", 1'b0, 2'b00, 1'b1, 32'h46, 32'h0, 2, 32'h0000_00FD, 1'b0, 0, 32'h0);
        txn("lh_46",  1'b0, 2'b01, 1'b0, 32'h46, 32'h0, 2, 32'h0000_71FD, 1'b0, 0, 32'h0);
        txn("lh_44",  1'b0, 2'b01, 1'b0, 32'h44, 32'h0, 2, 32'h0000_6806, 1'b0, 0, 32'h0);
        txn("lw_44",  1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 2, 32'h71FD_6806, 1'b0, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        txn("lw_46_mis", 1'b0, 2'b10, 1'b0, 32'h46, 32'h0, 1, 32'h0000_0000, 1'b1, 0, 32'h0);
`else
        txn("lw_46_mis", 1'b0, 2'b10, 1'b0, 32'h46, 32'h0, 2, 32'h71FD_6806, 1'b0, 0, 32'h0);
`endif

        txn("sb_47", 1'b1, 2'b00, 1'b0, 32'h47, 32'h0000_00AB, 3, 32'h0, 1'b0, 1, 32'hABFD_6806);
        check("sb_47.mem", dmem[17], 32'hABFD_6806);
        txn("lw_44b",  1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 2, 32'hABFD_6806, 1'b0, 0, 32'h0);
        txn("lh_46b",  1'b0, 2'b01, 1'b0, 32'h46, 32'h0, 2, 32'hFFFF_ABFD, 1'b0, 0, 32'h0);
        txn("lhu_46b", 1'b0, 2'b01, 1'b1, 32'h46, 32'h0, 2, 32'h0000_ABFD, 1'b0, 0, 32'h0);
        txn("sh_44", 1'b1, 2'b01, 1'b0, 32'h44, 32'h1234_BEEF, 3, 32'h0, 1'b0, 1, 32'hABFD_BEEF);
        check("sh_44.mem", dmem[17], 32'hABFD_BEEF);
        txn("sw_34", 1'b1, 2'b10, 1'b0, 32'h34, 32'h1234_5678, 2, 32'h0, 1'b0, 1, 32'h1234_5678);
        check("sw_34.mem", dmem[13], 32'h1234_5678);
        check("sw_34.mem_addr", mem_addr, 32'd13);

        // Response back-pressure: hold resp_ready low while a store request is offered.
        run_req("stall", 1'b0, 2'b00, 1'b0, 32'h46, 32'h0, lat, wr_cnt, wseen);
        check("stall.latency", lat, 2);
        check("stall.rdata", resp_rdata, 32'hFFFF_FFFD);
        held = resp_rdata;
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h34; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.valid", {31'b0, resp_valid}, 32'd1);
            check("stall.hold", resp_rdata, held);
            check("stall.req_ready", {31'b0, req_ready}, 32'd0);
            check("stall.r_wbar", {31'b0, mem_r_wbar}, 32'd1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("stall.release_ready", {31'b0, req_ready}, 32'd1);
        check("stall.release_valid", {31'b0, resp_valid}, 32'd0);
        check("stall.mem13", dmem[13], 32'h1234_5678);

        // Reset landing on the write cycle of a byte store.
        check("rst_wr.req_ready", {31'b0, req_ready}, 32'd1);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h35; req_wdata = 32'h99;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_wr.in_write", {31'b0, mem_r_wbar}, 32'd0);
        check("rst_wr.wdata", mem_wdata, 32'h1234_9978);
        reset = 1'b1;
        tick();
        check_reset_values("rst_wr");
        reset = 1'b0;
        tick();
        check("rst_wr.no_resp", {31'b0, resp_valid}, 32'd0);
        check("rst_wr.idle", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
